// File: rtl/pacman_display_timing_pkg.sv
// rtl/pacman_display_timing_pkg.sv - VGA mode timing constants and game field size shared by the display timing slice
package pacman_display_timing_pkg;

  // 640x480@60
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600@60
  localparam int VGA800_H_ACTIVE = 800;
  localparam int VGA800_H_FP     = 40;
  localparam int VGA800_H_SYNC   = 128;
  localparam int VGA800_H_BP     = 88;
  localparam int VGA800_V_ACTIVE = 600;
  localparam int VGA800_V_FP     = 1;
  localparam int VGA800_V_SYNC   = 4;
  localparam int VGA800_V_BP     = 23;

  localparam int PACMAN_H_VISIBLE_AREA = 224;
  localparam int PACMAN_V_VISIBLE_AREA = 288;

  // Counter width that stays at least one bit for a range of a single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pacman_display_timing_scaled_axis_counter.sv
// rtl/pacman_display_timing_scaled_axis_counter.sv - one raster axis: position, sub-pixel phase and game coordinate
module scaled_axis_counter
  import pacman_display_timing_pkg::*;
#(
  parameter int TOTAL = 800,
  parameter int OFF   = 208,
  parameter int LEN   = 224,
  parameter int SCALE = 1,
  localparam int PW   = $clog2(TOTAL),
  localparam int CW   = $clog2(LEN),
  localparam int SW   = cnt_w(SCALE)
) (
  input  logic          vga_pix_clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] pos,
  output logic [SW-1:0] sub,
  output logic [CW-1:0] coord,
  output logic          in_win,
  output logic          wrap
);

  localparam logic [PW-1:0] LAST     = PW'(TOTAL - 1);
  localparam logic [PW-1:0] WIN_LO   = PW'(OFF);
  localparam logic [PW-1:0] WIN_HI   = PW'(OFF + LEN * SCALE);
  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);

  logic [PW-1:0] pos_next;
  logic          next_in_win;

  assign wrap        = (pos == LAST);
  assign in_win      = (pos >= WIN_LO) && (pos < WIN_HI);
  assign pos_next    = wrap ? '0 : pos + PW'(1);
  assign next_in_win = (pos_next >= WIN_LO) && (pos_next < WIN_HI);

  // sub/coord track the position they accompany, so they restart on window entry
  // and return to 0 on exit; the window length guarantees coord never passes LEN-1.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      pos   <= '0;
      sub   <= '0;
      coord <= '0;
    end else if (en) begin
      pos <= pos_next;
      if (!next_in_win || !in_win) begin
        sub   <= '0;
        coord <= '0;
      end else if (sub == SUB_LAST) begin
        sub   <= '0;
        coord <= coord + CW'(1);
      end else begin
        sub <= sub + SW'(1);
      end
    end
  end

endmodule

// File: rtl/pacman_display_timing.sv
// rtl/pacman_display_timing.sv - VGA sync plus upscaled, centred game-space beam position for the game core
module pacman_display_timing
  import pacman_display_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter int SYNC_NEG = 1,
  parameter int GAME_W   = PACMAN_H_VISIBLE_AREA,
  parameter int GAME_H   = PACMAN_V_VISIBLE_AREA,
  parameter int SCALE    = 1
) (
  input  logic                      vga_pix_clk,
  input  logic                      rst,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      vga_de,
  output logic [$clog2(GAME_W)-1:0] sx,
  output logic [$clog2(GAME_H)-1:0] sy,
  output logic                      game_pix_stb,
  output logic                      frame_stb,
  output logic                      display_enabled
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_OFF   = (H_ACTIVE - GAME_W * SCALE) / 2;
  localparam int V_OFF   = (V_ACTIVE - GAME_H * SCALE) / 2;
  localparam int HPW     = $clog2(H_TOTAL);
  localparam int VPW     = $clog2(V_TOTAL);
  localparam int SW      = cnt_w(SCALE);

  localparam logic [HPW-1:0] HS_LO   = HPW'(H_ACTIVE + H_FP);
  localparam logic [HPW-1:0] HS_HI   = HPW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VPW-1:0] VS_LO   = VPW'(V_ACTIVE + V_FP);
  localparam logic [VPW-1:0] VS_HI   = VPW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HPW-1:0] H_VIS   = HPW'(H_ACTIVE);
  localparam logic [VPW-1:0] V_VIS   = VPW'(V_ACTIVE);
  localparam logic           SYNC_IDLE = (SYNC_NEG != 0);

  if (SCALE < 1 || SCALE > 4) begin : g_bad_scale
    $error("pacman_display_timing: SCALE must be in 1..4");
  end
  if (GAME_W * SCALE > H_ACTIVE) begin : g_bad_width
    $error("pacman_display_timing: scaled game width exceeds H_ACTIVE");
  end
  if (GAME_H * SCALE > V_ACTIVE) begin : g_bad_height
    $error("pacman_display_timing: scaled game height exceeds V_ACTIVE");
  end

  logic [HPW-1:0]            hcount;
  logic [VPW-1:0]            vcount;
  logic [SW-1:0]             hsub;
  logic [SW-1:0]             unused_vsub;
  logic [$clog2(GAME_W)-1:0] h_coord;
  logic [$clog2(GAME_H)-1:0] v_coord;
  logic                      h_in;
  logic                      v_in;
  logic                      h_wrap;
  logic                      unused_v_wrap;

  scaled_axis_counter #(
    .TOTAL(H_TOTAL), .OFF(H_OFF), .LEN(GAME_W), .SCALE(SCALE)
  ) u_h (
    .vga_pix_clk(vga_pix_clk),
    .rst        (rst),
    .en         (1'b1),
    .pos        (hcount),
    .sub        (hsub),
    .coord      (h_coord),
    .in_win     (h_in),
    .wrap       (h_wrap)
  );

  // The vertical axis steps once per line, on the horizontal wrap.
  scaled_axis_counter #(
    .TOTAL(V_TOTAL), .OFF(V_OFF), .LEN(GAME_H), .SCALE(SCALE)
  ) u_v (
    .vga_pix_clk(vga_pix_clk),
    .rst        (rst),
    .en         (h_wrap),
    .pos        (vcount),
    .sub        (unused_vsub),
    .coord      (v_coord),
    .in_win     (v_in),
    .wrap       (unused_v_wrap)
  );

  logic h_sync_act;
  logic v_sync_act;

  assign h_sync_act = (hcount >= HS_LO) && (hcount < HS_HI);
  assign v_sync_act = (vcount >= VS_LO) && (vcount < VS_HI);

  // Every output is one register stage behind the counters, all in the same stage.
  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      hsync           <= SYNC_IDLE;
      vsync           <= SYNC_IDLE;
      vga_de          <= 1'b0;
      sx              <= '0;
      sy              <= '0;
      game_pix_stb    <= 1'b0;
      frame_stb       <= 1'b0;
      display_enabled <= 1'b0;
    end else begin
      hsync           <= h_sync_act ^ SYNC_IDLE;
      vsync           <= v_sync_act ^ SYNC_IDLE;
      vga_de          <= (hcount < H_VIS) && (vcount < V_VIS);
      sx              <= h_coord;
      sy              <= v_coord;
      game_pix_stb    <= h_in && v_in && (hsub == '0);
      frame_stb       <= (hcount == '0) && (vcount == '0);
      display_enabled <= h_in && v_in;
    end
  end

endmodule

// File: tb/tb_pacman_display_timing.sv
// tb/tb_pacman_display_timing.sv - checks three timing configurations against an arithmetic raster model
module tb_pacman_display_timing;
  import pacman_display_timing_pkg::*;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int neg; int gw; int gh; int sc;
  } cfg_t;

  localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 224, 288, 1};
  localparam cfg_t C1 = '{VGA800_H_ACTIVE, VGA800_H_FP, VGA800_H_SYNC, VGA800_H_BP,
                          16, 1, 2, 2, 0, 224, 6, 2};
  localparam cfg_t C2 = '{20, 1, 2, 2, 14, 1, 1, 1, 1, 5, 4, 3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic hsync0, vsync0, de0, gps0, fs0, den0;
  logic [7:0] sx0;
  logic [8:0] sy0;
  logic hsync1, vsync1, de1, gps1, fs1, den1;
  logic [7:0] sx1;
  logic [2:0] sy1;
  logic hsync2, vsync2, de2, gps2, fs2, den2;
  logic [2:0] sx2;
  logic [1:0] sy2;

  pacman_display_timing u0 (
    .vga_pix_clk(clk), .rst(rst), .hsync(hsync0), .vsync(vsync0), .vga_de(de0),
    .sx(sx0), .sy(sy0), .game_pix_stb(gps0), .frame_stb(fs0), .display_enabled(den0)
  );

  pacman_display_timing #(
    .H_ACTIVE(C1.ha), .H_FP(C1.hfp), .H_SYNC(C1.hs), .H_BP(C1.hbp),
    .V_ACTIVE(C1.va), .V_FP(C1.vfp), .V_SYNC(C1.vs), .V_BP(C1.vbp),
    .SYNC_NEG(C1.neg), .GAME_W(C1.gw), .GAME_H(C1.gh), .SCALE(C1.sc)
  ) u1 (
    .vga_pix_clk(clk), .rst(rst), .hsync(hsync1), .vsync(vsync1), .vga_de(de1),
    .sx(sx1), .sy(sy1), .game_pix_stb(gps1), .frame_stb(fs1), .display_enabled(den1)
  );

  pacman_display_timing #(
    .H_ACTIVE(C2.ha), .H_FP(C2.hfp), .H_SYNC(C2.hs), .H_BP(C2.hbp),
    .V_ACTIVE(C2.va), .V_FP(C2.vfp), .V_SYNC(C2.vs), .V_BP(C2.vbp),
    .SYNC_NEG(C2.neg), .GAME_W(C2.gw), .GAME_H(C2.gh), .SCALE(C2.sc)
  ) u2 (
    .vga_pix_clk(clk), .rst(rst), .hsync(hsync2), .vsync(vsync2), .vga_de(de2),
    .sx(sx2), .sy(sy2), .game_pix_stb(gps2), .frame_stb(fs2), .display_enabled(den2)
  );

  logic [29:0] o0, o1, o2;
  assign o0 = {hsync0, vsync0, de0, den0, gps0, fs0, 12'(sx0), 12'(sy0)};
  assign o1 = {hsync1, vsync1, de1, den1, gps1, fs1, 12'(sx1), 12'(sy1)};
  assign o2 = {hsync2, vsync2, de2, den2, gps2, fs2, 12'(sx2), 12'(sy2)};

  int total = 0;
  int bad = 0;
  int pos = 0;
  int cyc = 0;
  bit stats_on = 1'b0;
  bit have_fs = 1'b0;
  int last_fs = 0;
  int de_cnt = 0;
  int hs_low10 = 0;
  int de_line10 = 0;
  int ivq[$];
  int deq[$];

  // Expected outputs for the beam at linear position p since the last reset.
  function automatic logic [29:0] model(input cfg_t c, input int p);
    int ht, vt, h, v, hoff, voff, sxv, syv;
    logic hw, vw, hs, vs, de, gps, fs, neg;
    ht   = c.ha + c.hfp + c.hs + c.hbp;
    vt   = c.va + c.vfp + c.vs + c.vbp;
    h    = p % ht;
    v    = (p / ht) % vt;
    hoff = (c.ha - c.gw * c.sc) / 2;
    voff = (c.va - c.gh * c.sc) / 2;
    hw   = (h >= hoff) && (h < hoff + c.gw * c.sc);
    vw   = (v >= voff) && (v < voff + c.gh * c.sc);
    sxv  = hw ? (h - hoff) / c.sc : 0;
    syv  = vw ? (v - voff) / c.sc : 0;
    hs   = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
    vs   = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
    de   = (h < c.ha) && (v < c.va);
    gps  = hw && vw && ((h - hoff) % c.sc == 0);
    fs   = (h == 0) && (v == 0);
    neg  = (c.neg != 0);
    return {hs ^ neg, vs ^ neg, de, hw && vw, gps, fs, 12'(sxv), 12'(syv)};
  endfunction

  function automatic logic [29:0] rst_exp(input cfg_t c);
    logic neg;
    neg = (c.neg != 0);
    return {neg, neg, 28'b0};
  endfunction

  task automatic check(input string tag, input logic [29:0] obs, input logic [29:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r);
    logic was_rst;
    rst = r;
    @(posedge clk);
    was_rst = rst;
    #1;
    check($sformatf("u0 cyc%0d", cyc), o0, was_rst ? rst_exp(C0) : model(C0, pos));
    check($sformatf("u1 cyc%0d", cyc), o1, was_rst ? rst_exp(C1) : model(C1, pos));
    check($sformatf("u2 cyc%0d", cyc), o2, was_rst ? rst_exp(C2) : model(C2, pos));
    if (stats_on && !was_rst) begin
      if (fs1) begin
        if (have_fs) begin
          ivq.push_back(cyc - last_fs);
          deq.push_back(de_cnt);
        end
        have_fs = 1'b1;
        last_fs = cyc;
        de_cnt  = 0;
      end
      if (de1) de_cnt++;
      if (pos / 800 == 10) begin
        if (!hsync0) hs_low10++;
        if (de0) de_line10++;
      end
    end
    pos = was_rst ? 0 : pos + 1;
    cyc++;
  endtask

  initial begin
    int hold;

    for (int i = 0; i < 3; i++) step(1'b1);

    stats_on = 1'b1;
    for (int i = 0; i < 45000; i++) step(1'b0);
    stats_on = 1'b0;

    check("u0 hsync low cycles line10", 30'(hs_low10), 30'(96));
    check("u0 vga_de cycles line10", 30'(de_line10), 30'(640));
    check("u1 frame count", 30'(ivq.size()), 30'(2));
    for (int i = 0; i < ivq.size(); i++) begin
      check($sformatf("u1 frame period %0d", i), 30'(ivq[i]), 30'(1056 * 21));
      check($sformatf("u1 de per frame %0d", i), 30'(deq[i]), 30'(800 * 16));
    end

    // Mid-line reset on the default geometry, held for three cycles.
    for (int i = 0; i < 800 && (pos % 800) != 300; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    step(1'b0);
    check("u0 frame_stb after rst", 30'({fs0, sx0, sy0}), 30'({1'b1, 17'b0}));

    hold = 0;
    for (int i = 0; i < 6000; i++) begin
      if (hold == 0 && $urandom_range(0, 399) == 0) hold = $urandom_range(1, 4);
      if (hold > 0) begin
        step(1'b1);
        hold--;
      end else begin
        step(1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
